// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle RV32I load/store sequencer for a synchronous-read word RAM
// Ports: clk_i, rst_ni (sync active-low); req_i/we_i/funct3_i/addr_i/wdata_i request from datapath;
//        stall_o/done_o/err_o/rdata_o status and load result; mem_addr_o/mem_re_o/mem_we_o/mem_wdata_o/mem_rdata_i RAM port
module mem_access_ctrl #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_ADDR_WIDTH = ADDRESS_WIDTH - 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [2:0]                funct3_i,
    input  logic [ADDRESS_WIDTH-1:0]  addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      stall_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [31:0]               rdata_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_re_o,
    output logic                      mem_we_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_e;
    state_e                   state_q, state_d;
    logic                     we_q, we_d, err_q, err_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
    logic                     illegal, misaligned;
    logic [4:0]               sh;
    logic [31:0]              lane, mask;
    always_comb begin
        illegal    = we_i ? (funct3_i[2] || funct3_i[1:0] == 2'b11)
                          : (funct3_i[1:0] == 2'b11 || funct3_i == 3'b110);
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        // halves are aligned, so the byte offset doubles as the half-lane shift
        sh         = {addr_q[1:0], 3'b000};
        lane       = mem_rdata_i >> sh;
        mask       = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: if (req_i) begin
                we_d     = we_i;
                funct3_d = funct3_i;
                addr_d   = addr_i;
                wdata_d  = wdata_i;
                rdata_d  = '0;
                err_d    = illegal || misaligned;
                state_d  = err_d ? DONE : (we_i && funct3_i[1:0] == 2'b10) ? WRITE : READ;
            end
            READ: state_d = WAIT;
            WAIT: begin
                merge_d = we_q ? (mem_rdata_i & ~mask) | ((wdata_q << sh) & mask) : merge_q;
                rdata_d = we_q ? rdata_q :
                          funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & lane[7]}}, lane[7:0]} :
                          funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} :
                          mem_rdata_i;
                state_d = we_q ? WRITE : DONE;
            end
            WRITE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
        end
    end
    assign stall_o     = state_q == READ || state_q == WAIT || state_q == WRITE || (state_q == IDLE && req_i);
    assign done_o      = state_q == DONE;
    assign err_o       = state_q == DONE && err_q;
    assign rdata_o     = rdata_q;
    assign mem_re_o    = state_q == READ;
    assign mem_we_o    = state_q == WRITE;
    assign mem_addr_o  = (state_q == READ || state_q == WRITE) ? addr_q[ADDRESS_WIDTH-1:2] : '0;
    assign mem_wdata_o = state_q != WRITE ? '0 : funct3_q[1:0] == 2'b10 ? wdata_q : merge_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a byte-level memory model
module tb_mem_access_ctrl;
    logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0, init_en = 1'b1;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, done_o, err_o, mem_re_o, mem_we_o;
    logic [31:0] rdata_o, mem_wdata_o, mem_rdata_i;
    logic [29:0] mem_addr_o;
    int          vectors = 0, miscompares = 0;
    logic [31:0] ram [256];
    logic [7:0]  ref_mem [1024];
    int          o_lat, o_re_cyc, o_we_cyc, o_re_n, o_we_n, o_both, o_stall_bad, o_addr_bad;
    logic        o_err;
    logic [31:0] o_rdata, o_wdata, o_we_addr;
    int          e_lat;
    logic        e_err, e_re, e_we;
    logic [31:0] e_rdata, e_wword;

    mem_access_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input int i);
        return (i == 32'h40) ? 32'h8899AABB : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk_i) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            if (mem_we_o) ram[mem_addr_o[7:0]] <= mem_wdata_o;
            if (mem_re_o) mem_rdata_i <= ram[mem_addr_o[7:0]];
        end
    end

    // Reference: byte-addressed memory, access legality and the architectural latency of each access class.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz, ai, b;
        logic [31:0] w;
        logic ill;
        ai  = int'(a[9:0]);
        b   = ai - (ai % 4);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ill = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e_err   = ill || (ai % sz) != 0;
        e_rdata = '0;
        e_wword = '0;
        e_re    = !e_err && !(we && sz == 4);
        e_we    = !e_err && we;
        e_lat   = e_err ? 1 : !we ? 3 : (sz == 4) ? 2 : 4;
        if (!e_err && we) begin
            for (int i = 0; i < sz; i++) ref_mem[ai + i] = wd[8*i +: 8];
            e_wword = {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
        end else if (!e_err) begin
            w = '0;
            for (int i = 0; i < sz; i++) w[8*i +: 8] = ref_mem[ai + i];
            if (!f3[2] && sz == 1) w = {{24{w[7]}}, w[7:0]};
            if (!f3[2] && sz == 2) w = {{16{w[15]}}, w[15:0]};
            e_rdata = w;
        end
    endtask

    // Drives one request in the next IDLE cycle and records what the DUT did, cycle by cycle.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        o_lat = -1; o_re_cyc = -1; o_we_cyc = -1; o_re_n = 0; o_we_n = 0;
        o_both = 0; o_stall_bad = 0; o_addr_bad = 0;
        o_err = 1'bx; o_rdata = 'x; o_wdata = 'x; o_we_addr = 'x;
        #1;
        if (stall_o !== 1'b1) o_stall_bad++;
        for (int c = 1; c <= 8 && o_lat < 0; c++) begin
            @(negedge clk_i);
            if (mem_re_o) begin
                o_re_n++;
                if (o_re_cyc < 0) o_re_cyc = c;
                if (mem_addr_o !== a[31:2]) o_addr_bad++;
            end
            if (mem_we_o) begin
                o_we_n++;
                o_we_cyc  = c;
                o_wdata   = mem_wdata_o;
                o_we_addr = {2'b00, mem_addr_o};
                if (mem_addr_o !== a[31:2]) o_addr_bad++;
            end
            if (mem_re_o && mem_we_o) o_both++;
            if (stall_o === done_o) o_stall_bad++;
            if (done_o) begin
                o_lat   = c;
                o_err   = err_o;
                o_rdata = rdata_o;
            end
        end
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i / 4)[8*(i % 4) +: 8];
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({done_o, err_o, rdata_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: got re=%b we=%b done=%b rdata=%h", mem_re_o, mem_we_o, done_o, rdata_o); end
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        init_en = 1'b0;
        rst_ni  = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad [5] = '{32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
        logic [31:0] ex [5] = '{32'hFFFFFF88, 32'h00000099, 32'h00008899, 32'hFFFFAABB, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, f3[i], ad[i], 32'h0);
            vectors++;
            if (o_rdata !== ex[i]) begin miscompares++; $display("FAIL load_data[%0d]: got %h want %h", i, o_rdata, ex[i]); end
            vectors++;
            if (o_lat !== 3 || o_re_cyc !== 1 || o_stall_bad !== 0 || o_err !== 1'b0)
                begin miscompares++; $display("FAIL load_timing[%0d]: got done@%0d re@%0d stallbad=%0d err=%b want done@3 re@1", i, o_lat, o_re_cyc, o_stall_bad, o_err); end
        end
    endtask

    task automatic test_sb;
        run_access(1'b1, 3'b000, 32'h101, 32'h12345612);
        model(1'b1, 3'b000, 32'h101, 32'h12345612);
        vectors++;
        if (o_re_cyc !== 1 || o_we_cyc !== 3 || o_lat !== 4)
            begin miscompares++; $display("FAIL sb_timing: got re@%0d we@%0d done@%0d want 1/3/4", o_re_cyc, o_we_cyc, o_lat); end
        vectors++;
        if (o_wdata !== 32'h889912BB) begin miscompares++; $display("FAIL sb_wdata: got %h want 889912bb", o_wdata); end
        run_access(1'b0, 3'b010, 32'h100, 32'h0);
        vectors++;
        if (o_rdata !== 32'h889912BB) begin miscompares++; $display("FAIL sb_readback: got %h want 889912bb", o_rdata); end
    endtask

    task automatic test_sw;
        run_access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
        model(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
        vectors++;
        if (o_we_cyc !== 1 || o_re_n !== 0 || o_lat !== 2)
            begin miscompares++; $display("FAIL sw_timing: got we@%0d reads=%0d done@%0d want 1/0/2", o_we_cyc, o_re_n, o_lat); end
        vectors++;
        if (o_we_addr !== 32'h41 || o_wdata !== 32'hDEADBEEF)
            begin miscompares++; $display("FAIL sw_port: got addr %h data %h want 41 deadbeef", o_we_addr, o_wdata); end
    endtask

    task automatic test_errors;
        logic        we [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            run_access(we[i], f3[i], ad[i], 32'hFFFFFFFF);
            vectors++;
            if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || o_re_n !== 0 || o_we_n !== 0)
                begin miscompares++; $display("FAIL error[%0d]: got done@%0d err=%b rdata=%h re=%0d we=%0d want done@1 err=1 rdata=0 no strobes", i, o_lat, o_err, o_rdata, o_re_n, o_we_n); end
        end
    endtask

    task automatic test_reset_mid;
        int we_seen = 0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h101; wdata_i = 32'h000000AA;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if ({stall_o, done_o, err_o, rdata_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o} !== '0)
            begin miscompares++; $display("FAIL reset_mid_outputs: got stall=%b we=%b addr=%h wdata=%h want all 0", stall_o, mem_we_o, mem_addr_o, mem_wdata_o); end
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (mem_we_o) we_seen++;
        end
        vectors++;
        if (we_seen !== 0) begin miscompares++; $display("FAIL reset_mid_write: got %0d writes want 0", we_seen); end
        run_access(1'b0, 3'b010, 32'h100, 32'h0);
        vectors++;
        if (o_lat !== 3 || o_rdata !== 32'h889912BB)
            begin miscompares++; $display("FAIL reset_mid_lw: got done@%0d %h want done@3 889912bb", o_lat, o_rdata); end
    endtask

    task automatic test_back_to_back;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            run_access(we, f3, a, wd);
            model(we, f3, a, wd);
            vectors++;
            if (o_lat !== e_lat || o_err !== e_err)
                begin miscompares++; $display("FAIL rnd_done[%0d]: got done@%0d err=%b want done@%0d err=%b", n, o_lat, o_err, e_lat, e_err); end
            if (!we || e_err) begin
                vectors++;
                if (o_rdata !== e_rdata) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o_rdata, e_rdata); end
            end
            vectors++;
            if (o_re_n !== int'(e_re) || o_we_n !== int'(e_we) || (e_re && o_re_cyc !== 1) || (e_we && o_we_cyc !== e_lat - 1))
                begin miscompares++; $display("FAIL rnd_strobes[%0d]: got re=%0d@%0d we=%0d@%0d want re=%b we=%b", n, o_re_n, o_re_cyc, o_we_n, o_we_cyc, e_re, e_we); end
            if (e_we) begin
                vectors++;
                if (o_wdata !== e_wword) begin miscompares++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_wdata, e_wword); end
            end
            vectors++;
            if (o_both !== 0 || o_stall_bad !== 0 || o_addr_bad !== 0)
                begin miscompares++; $display("FAIL rnd_protocol[%0d]: got overlap=%0d stallbad=%0d addrbad=%0d want 0", n, o_both, o_stall_bad, o_addr_bad); end
        end
    endtask

    task automatic test_ram_image;
        int bad = 0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++)
            if (ram[i] !== {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]}) bad++;
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL ram_image: got %0d differing words want 0", bad); end
    endtask

    initial begin
        test_reset;
        test_loads;
        test_sb;
        test_sw;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_ram_image;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
